mc_controller_v2: RTL and testbench

Parametrised multicycle RISC-V control unit: the successor to the single-speed lab controller. It sits between the instruction register and the datapath muxes and enables of the multicycle processor. Beyond the first generation it adds:
- wait-stated memory with a request/ready handshake and a timeout watchdog;
- `lui` and `jalr`;
- optional full conditional-branch support;
- a sticky fault state for illegal opcodes and memory timeouts.

---
 rtl/mc_controller_v2.sv | 248 ++++++++++++++++++++++++
 tb/tb_mc_controller_v2.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_v2.sv
// Multicycle RISC-V control unit with wait-stated memory, watchdog and sticky fault.
// Define MC_BRANCH_EXT_EN to enable the full conditional-branch set (otherwise beq only).
module mc_controller_v2 #(
  parameter int MEM_TIMEOUT      = 16,
  parameter bit FAULT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
  input  logic       Ovf,
  input  logic       Carry,
  input  logic       MemReady,
  output logic       MemReq,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Fault,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_BRANCH   = 4'd13,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          mem_req, ir_wr, pc_wr, reg_wr, mem_wr;
  logic          br_legal, br_take, wdog_hit;
  logic [2:0]    alu_dec;
  state_t        illegal_nxt;

`ifdef MC_BRANCH_EXT_EN
  always_comb begin
    br_legal = 1'b1;
    br_take  = 1'b0;
    case (funct3)
      3'b000:  br_take = Zero;
      3'b001:  br_take = ~Zero;
      3'b100:  br_take = Neg ^ Ovf;
      3'b101:  br_take = ~(Neg ^ Ovf);
      3'b110:  br_take = ~Carry;
      3'b111:  br_take = Carry;
      default: br_legal = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = ^{Neg, Ovf, Carry};
  assign br_legal     = (funct3 == 3'b000);
  assign br_take      = Zero;
`endif

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_ST:   ImmSrc = 3'b001;
      OP_BR:   ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  assign illegal_nxt = FAULT_ON_ILLEGAL ? S_FAULT : S_FETCH;
  // Fires on the last permitted wait cycle; a same-cycle MemReady completes instead.
  assign wdog_hit = (MEM_TIMEOUT != 0) && mem_req && !MemReady &&
                    (wdog_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (MemReady) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_R:          state_d = S_EXECR;
          OP_I:          state_d = S_EXECI;
          OP_LD, OP_ST:  state_d = S_MEMADR;
          OP_BR:         state_d = br_legal ? S_BRANCH : illegal_nxt;
          OP_JAL:        state_d = S_JAL;
          OP_JALR:       state_d = S_JALR_ADR;
          OP_LUI:        state_d = S_LUI;
          default:       state_d = illegal_nxt;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_ST) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        mem_wr  = MemReady;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_wr  = 1'b1;
        state_d = S_FETCH;
      end
      // JALR shares JAL's outputs: PC takes the target held in ALUOut, ALU forms the link.
      S_JAL, S_JALR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_wr   = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pc_wr      = br_take;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (wdog_hit) state_d = S_FAULT;
  end

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q)        wdog_d = '0;
    else if (mem_req && !MemReady) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  assign MemReq   = mem_req & reset_n;
  assign IRWrite  = ir_wr & reset_n;
  assign PCWrite  = pc_wr & reset_n;
  assign RegWrite = reg_wr & reset_n;
  assign MemWrite = mem_wr & reset_n;
  assign Fault    = (state_q == S_FAULT);
  assign State    = state_q;

endmodule

// File: tb/tb_mc_controller_v2.sv
// Bench for mc_controller_v2: two instances (strict watchdog/fault vs. no watchdog/NOP on illegal)
// driven in lockstep, checked per cycle against an instruction-level reference model.
module tb_mc_controller_v2;

  localparam int TMO_A = 4;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4;
  localparam int S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_JAL = 9;
  localparam int S_JALR_ADR = 10, S_JALR = 11, S_LUI = 12, S_BRANCH = 13, S_FAULT = 15;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, irw, pcw, rgw, mw, flt;
    logic [2:0] imm;
    logic [1:0] sa, sb, rs;
    logic       adr;
    logic [2:0] alu;
  } ctl_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, funct7b5, Zero, Neg, Ovf, Carry, MemReady;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       a_MemReq, a_AdrSrc, a_IRWrite, a_PCWrite, a_RegWrite, a_MemWrite, a_Fault;
  logic [2:0] a_ImmSrc, a_ALUControl;
  logic [1:0] a_ALUSrcA, a_ALUSrcB, a_ResultSrc;
  logic [3:0] a_State;
  logic       b_MemReq, b_AdrSrc, b_IRWrite, b_PCWrite, b_RegWrite, b_MemWrite, b_Fault;
  logic [2:0] b_ImmSrc, b_ALUControl;
  logic [1:0] b_ALUSrcA, b_ALUSrcB, b_ResultSrc;
  logic [3:0] b_State;

  mc_controller_v2 #(.MEM_TIMEOUT(TMO_A), .FAULT_ON_ILLEGAL(1'b1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry), .MemReady(MemReady),
    .MemReq(a_MemReq), .ImmSrc(a_ImmSrc), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
    .ResultSrc(a_ResultSrc), .AdrSrc(a_AdrSrc), .ALUControl(a_ALUControl),
    .IRWrite(a_IRWrite), .PCWrite(a_PCWrite), .RegWrite(a_RegWrite), .MemWrite(a_MemWrite),
    .Fault(a_Fault), .State(a_State)
  );

  mc_controller_v2 #(.MEM_TIMEOUT(0), .FAULT_ON_ILLEGAL(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .Carry(Carry), .MemReady(MemReady),
    .MemReq(b_MemReq), .ImmSrc(b_ImmSrc), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .ResultSrc(b_ResultSrc), .AdrSrc(b_AdrSrc), .ALUControl(b_ALUControl),
    .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .RegWrite(b_RegWrite), .MemWrite(b_MemWrite),
    .Fault(b_Fault), .State(b_State)
  );

  ctl_t act_a, act_b;
  assign act_a = {a_State, a_MemReq, a_IRWrite, a_PCWrite, a_RegWrite, a_MemWrite, a_Fault,
                  a_ImmSrc, a_ALUSrcA, a_ALUSrcB, a_ResultSrc, a_AdrSrc, a_ALUControl};
  assign act_b = {b_State, b_MemReq, b_IRWrite, b_PCWrite, b_RegWrite, b_MemWrite, b_Fault,
                  b_ImmSrc, b_ALUSrcA, b_ALUSrcB, b_ResultSrc, b_AdrSrc, b_ALUControl};

  // scoreboard
  logic [22:0] exp_a_q[$], msk_a_q[$], exp_b_q[$], msk_b_q[$];
  int checks = 0, errors = 0, cyc = 0;
  bit a_fault = 1'b0;

  int   plan_st[$], plan_k[$];
  logic plan_mr[$];

  // reference model
  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == OP_ST)  return 3'b001;
    if (o == OP_BR)  return 3'b010;
    if (o == OP_JAL) return 3'b011;
    if (o == OP_LUI) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (f7 && o[5]) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic bit br_ok(input logic [2:0] f3);
`ifdef MC_BRANCH_EXT_EN
    return (f3 != 3'b010) && (f3 != 3'b011);
`else
    return f3 == 3'b000;
`endif
  endfunction

  // fl = {Zero, Neg, Ovf, Carry}
  function automatic logic br_cond(input logic [2:0] f3, input logic [3:0] fl);
`ifdef MC_BRANCH_EXT_EN
    logic lt;
    lt = fl[2] ^ fl[1];
    case (f3)
      3'b001:  return ~fl[3];
      3'b100:  return lt;
      3'b101:  return ~lt;
      3'b110:  return ~fl[0];
      3'b111:  return fl[0];
      default: return fl[3];
    endcase
`else
    return fl[3] & (f3 == 3'b000);
`endif
  endfunction

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3);
    if (o == OP_BR) return br_ok(f3);
    return o == OP_R || o == OP_I || o == OP_LD || o == OP_ST ||
           o == OP_JAL || o == OP_JALR || o == OP_LUI;
  endfunction

  function automatic void exp_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic [3:0] fl, input logic mr,
                                  input logic rst, output ctl_t v, output ctl_t m);
    int s;
    s = rst ? st : S_FETCH;
    v = '0; m = '0;
    v.st = 4'(s); m.st = '1;
    m.mreq = 1; m.irw = 1; m.pcw = 1; m.rgw = 1; m.mw = 1; m.flt = 1;
    v.flt = (s == S_FAULT);
    v.imm = imm_of(o); m.imm = '1;
    case (s)
      S_FETCH: begin
        v.mreq = rst; v.irw = mr & rst; v.pcw = mr & rst;
        v.sa = 2'b00; v.sb = 2'b10; v.alu = 3'b000; v.rs = 2'b10; v.adr = 1'b0;
        m.sa = '1; m.sb = '1; m.alu = '1; m.rs = '1; m.adr = 1;
      end
      S_DECODE, S_MEMADR, S_JALR_ADR, S_LUI: begin
        v.sa = (s == S_DECODE) ? 2'b01 : (s == S_LUI) ? 2'b11 : 2'b10;
        v.sb = 2'b01; v.alu = 3'b000;
        m.sa = '1; m.sb = '1; m.alu = '1;
      end
      S_MEMREAD, S_MEMWRITE: begin
        v.mreq = 1; v.adr = 1; m.adr = 1;
        v.mw = (s == S_MEMWRITE) && mr;
      end
      S_MEMWB: begin v.rs = 2'b01; m.rs = '1; v.rgw = 1; end
      S_ALUWB: begin v.rs = 2'b00; m.rs = '1; v.rgw = 1; end
      S_EXECR, S_EXECI: begin
        v.sa = 2'b10; v.sb = (s == S_EXECI) ? 2'b01 : 2'b00; v.alu = alu_of(o, f3, f7);
        m.sa = '1; m.sb = '1; m.alu = '1;
      end
      S_JAL, S_JALR: begin
        v.sa = 2'b01; v.sb = 2'b10; v.alu = 3'b000; v.rs = 2'b00; v.pcw = 1;
        m.sa = '1; m.sb = '1; m.alu = '1; m.rs = '1;
      end
      S_BRANCH: begin
        v.sa = 2'b10; v.sb = 2'b00; v.alu = 3'b001; v.rs = 2'b00; v.pcw = br_cond(f3, fl);
        m.sa = '1; m.sb = '1; m.alu = '1; m.rs = '1;
      end
      default: ;
    endcase
  endfunction

  // driver tasks
  task automatic drive_cycle(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int st, input int k, input logic mr, input logic rst,
                             input logic [3:0] fl);
    ctl_t v, m;
    @(posedge clk); #1;
    reset_n = rst; op = o; funct3 = f3; funct7b5 = f7; MemReady = mr;
    {Zero, Neg, Ovf, Carry} = fl;
    cyc++;
    exp_out(st, o, f3, f7, fl, mr, rst, v, m);
    exp_b_q.push_back(v); msk_b_q.push_back(m);
    if (rst && a_fault) exp_out(S_FAULT, o, f3, f7, fl, mr, rst, v, m);
    exp_a_q.push_back(v); msk_a_q.push_back(m);
    if (rst && !a_fault) begin
      if (st == S_DECODE && !legal(o, f3)) a_fault = 1'b1;
      if (k == TMO_A - 1 && !mr)          a_fault = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      drive_cycle(7'($urandom), 3'($urandom), 1'($urandom), S_FETCH, -1,
                  1'($urandom), 1'b0, 4'($urandom));
    a_fault = 1'b0;
  endtask

  task automatic add_step(input int st, input int k, input logic mr);
    plan_st.push_back(st); plan_k.push_back(k); plan_mr.push_back(mr);
  endtask

  task automatic add_wait(input int st, input int w);
    for (int i = 0; i <= w; i++) add_step(st, i, (i == w));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int wf, input int wm, input int max_cyc,
                           input bit fix_en, input logic [3:0] fix_fl);
    int n;
    plan_st.delete(); plan_k.delete(); plan_mr.delete();
    add_wait(S_FETCH, wf);
    add_step(S_DECODE, -1, 1'($urandom));
    case (o)
      OP_R:    begin add_step(S_EXECR, -1, 1'($urandom)); add_step(S_ALUWB, -1, 1'($urandom)); end
      OP_I:    begin add_step(S_EXECI, -1, 1'($urandom)); add_step(S_ALUWB, -1, 1'($urandom)); end
      OP_LD:   begin add_step(S_MEMADR, -1, 1'($urandom)); add_wait(S_MEMREAD, wm);
                     add_step(S_MEMWB, -1, 1'($urandom)); end
      OP_ST:   begin add_step(S_MEMADR, -1, 1'($urandom)); add_wait(S_MEMWRITE, wm); end
      OP_BR:   if (br_ok(f3)) add_step(S_BRANCH, -1, 1'($urandom));
      OP_JAL:  begin add_step(S_JAL, -1, 1'($urandom)); add_step(S_ALUWB, -1, 1'($urandom)); end
      OP_JALR: begin add_step(S_JALR_ADR, -1, 1'($urandom)); add_step(S_JALR, -1, 1'($urandom));
                     add_step(S_ALUWB, -1, 1'($urandom)); end
      OP_LUI:  begin add_step(S_LUI, -1, 1'($urandom)); add_step(S_ALUWB, -1, 1'($urandom)); end
      default: ;
    endcase
    n = (max_cyc > 0 && max_cyc < plan_st.size()) ? max_cyc : plan_st.size();
    for (int i = 0; i < n; i++)
      drive_cycle(o, f3, f7, plan_st[i], plan_k[i], plan_mr[i], 1'b1,
                  fix_en ? fix_fl : 4'($urandom));
  endtask

  // monitor
  always @(negedge clk) begin
    logic [22:0] e, m;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front(); m = msk_a_q.pop_front();
      checks++;
      if (((act_a ^ e) & m) != 0) begin
        errors++;
        $display("FAIL dut_a cycle %0d: got %h want %h mask %h", cyc, act_a, e, m);
      end
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front(); m = msk_b_q.pop_front();
      checks++;
      if (((act_b ^ e) & m) != 0) begin
        errors++;
        $display("FAIL dut_b cycle %0d: got %h want %h mask %h", cyc, act_b, e, m);
      end
    end
  end

  // stimulus
  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    int cls, wf, wm, mc;
    reset_n = 1'b0; op = OP_R; funct3 = '0; funct7b5 = 1'b0; MemReady = 1'b0;
    {Zero, Neg, Ovf, Carry} = '0;
    do_reset(3);

    run_instr(OP_R,    3'b000, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_R,    3'b000, 1'b1, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_I,    3'b000, 1'b1, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_R,    3'b010, 1'b0, 1, 0, 0, 1'b0, 4'h0);
    run_instr(OP_I,    3'b110, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_R,    3'b111, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_I,    3'b001, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_LD,   3'b010, 1'b0, 0, 3, 0, 1'b0, 4'h0);
    run_instr(OP_ST,   3'b010, 1'b0, 2, 2, 0, 1'b0, 4'h0);
    run_instr(OP_JAL,  3'b000, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_JALR, 3'b000, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_LUI,  3'b000, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_BR,   3'b000, 1'b0, 0, 0, 0, 1'b1, 4'b1000);
    run_instr(OP_BR,   3'b000, 1'b0, 0, 0, 0, 1'b1, 4'b0111);
    run_instr(OP_R,    3'b000, 1'b0, 3, 0, 0, 1'b0, 4'h0);

    // fetch stuck beyond the watchdog: instance A faults, B keeps running
    run_instr(OP_R,    3'b000, 1'b0, 6, 0, 0, 1'b0, 4'h0);
    run_instr(OP_LUI,  3'b000, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    do_reset(2);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    run_instr(OP_R,    3'b000, 1'b0, 0, 0, 0, 1'b0, 4'h0);
    do_reset(1);
    run_instr(OP_LD,   3'b010, 1'b0, 0, 4, 0, 1'b0, 4'h0);
    do_reset(1);
    run_instr(OP_LD,   3'b010, 1'b0, 0, 2, 4, 1'b0, 4'h0);
    do_reset(1);
    run_instr(OP_BR,   3'b100, 1'b0, 0, 0, 0, 1'b1, 4'b0100);
    do_reset(1);
    run_instr(OP_BR,   3'b111, 1'b0, 0, 0, 0, 1'b1, 4'b0000);
    do_reset(1);

    for (int i = 0; i < 250; i++) begin
      cls = $urandom_range(0, 9);
      case (cls)
        0, 9: o = OP_R;
        1: o = OP_I;
        2: o = OP_LD;
        3: o = OP_ST;
        4: o = OP_BR;
        5: o = OP_JAL;
        6: o = OP_JALR;
        7: o = OP_LUI;
        default: o = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      wf = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
      mc = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 6) : 0;
      run_instr(o, f3, 1'($urandom), wf, wm, mc, 1'b0, 4'h0);
      if (a_fault || mc > 0) do_reset($urandom_range(1, 2));
    end

    // final report
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_a_q.size() + exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_a_q.size() + exp_b_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
